// File: rtl/maze_pkg.sv
// maze_pkg: shared definitions for the grid-world maze environment.
// Contents: datapath widths, one-hot action codes, FSM state enum and the
// default parameter values (start/goal cell, rewards) used by
// maze_environment and maze_move_calc.
package maze_pkg;

  localparam int STATE_W  = 6;
  localparam int ACTION_W = 4;
  localparam int REWARD_W = 16;
  localparam int CELLS    = 1 << STATE_W;

  // One-hot move encoding; anything else is an illegal (blocked) action.
  localparam logic [ACTION_W-1:0] ACT_UP    = 4'b0001;
  localparam logic [ACTION_W-1:0] ACT_DOWN  = 4'b0010;
  localparam logic [ACTION_W-1:0] ACT_LEFT  = 4'b0100;
  localparam logic [ACTION_W-1:0] ACT_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    RESTART = 2'd2
  } fsm_state_t;

  localparam logic [STATE_W-1:0] DEF_START_STATE = 6'd0;
  localparam logic [STATE_W-1:0] DEF_GOAL_STATE  = 6'd63;

  localparam logic signed [REWARD_W-1:0] DEF_REWARD_GOAL = 16'sd100;
  localparam logic signed [REWARD_W-1:0] DEF_REWARD_STEP = -16'sd1;
  localparam logic signed [REWARD_W-1:0] DEF_REWARD_WALL = -16'sd10;

endpackage

// File: rtl/maze_move_calc.sv
// maze_move_calc: purely combinational move evaluation for one step.
// Ports:
//   position  in  current cell (row = [5:3], col = [2:0])
//   action    in  one-hot move request
//   wall_map  in  bit i set marks cell i as a wall
//   target    out cell after the move (equals position when blocked)
//   blocked   out move was off-grid, into a wall, or not one-hot
//   goal      out legal move that lands on GOAL_STATE
module maze_move_calc
  import maze_pkg::*;
#(
  parameter logic [STATE_W-1:0] GOAL_STATE = DEF_GOAL_STATE
) (
  input  logic [STATE_W-1:0]  position,
  input  logic [ACTION_W-1:0] action,
  input  logic [CELLS-1:0]    wall_map,
  output logic [STATE_W-1:0]  target,
  output logic                blocked,
  output logic                goal
);

  logic [2:0]         row;
  logic [2:0]         col;
  logic               illegal;
  logic [STATE_W-1:0] raw_target;

  // Work out the cell the action points at, flag moves that leave the
  // 8x8 grid or are not a single one-hot bit, then veto moves into walls.
  // A blocked move always reports the unchanged position as its target.
  always_comb begin
    row        = position[5:3];
    col        = position[2:0];
    illegal    = 1'b0;
    raw_target = position;
    case (action)
      ACT_UP: begin
        if (row == 3'd0) illegal = 1'b1;
        else             raw_target = {row - 3'd1, col};
      end
      ACT_DOWN: begin
        if (row == 3'd7) illegal = 1'b1;
        else             raw_target = {row + 3'd1, col};
      end
      ACT_LEFT: begin
        if (col == 3'd0) illegal = 1'b1;
        else             raw_target = {row, col - 3'd1};
      end
      ACT_RIGHT: begin
        if (col == 3'd7) illegal = 1'b1;
        else             raw_target = {row, col + 3'd1};
      end
      default: illegal = 1'b1;
    endcase
    blocked = illegal || wall_map[raw_target];
    target  = blocked ? position : raw_target;
    goal    = !blocked && (raw_target == GOAL_STATE);
  end

endmodule

// File: rtl/maze_environment.sv
// maze_environment: hardware grid-world environment for RL agents.
// An en strobe in IDLE latches the action; the following STEP cycle applies
// it and registers the result, so valid pulses two clocks after the en edge.
// Reaching the goal (or, with MAZE_ENV_TIMEOUT_EN defined, hitting MAX_STEPS)
// raises episode_done and passes through a one-cycle RESTART.
// Optional feature macro: MAZE_ENV_TIMEOUT_EN (episode timeout at MAX_STEPS).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en, action      step strobe and one-hot move
//   current_state   position before the last step
//   next_state      position after the last step
//   next_reward     signed reward for the last step
//   valid           one-cycle pulse with each step result
//   episode_done    one-cycle pulse with valid on goal/timeout
//   episode_count   completed episodes (wrapping)
//   step_count      steps in the current episode (saturating)
module maze_environment
  import maze_pkg::*;
#(
  parameter logic [STATE_W-1:0]         START_STATE = DEF_START_STATE,
  parameter logic [STATE_W-1:0]         GOAL_STATE  = DEF_GOAL_STATE,
  parameter logic [CELLS-1:0]           WALL_MAP    = 64'h0,
  parameter logic signed [REWARD_W-1:0] REWARD_GOAL = DEF_REWARD_GOAL,
  parameter logic signed [REWARD_W-1:0] REWARD_STEP = DEF_REWARD_STEP,
  parameter logic signed [REWARD_W-1:0] REWARD_WALL = DEF_REWARD_WALL,
  parameter logic [15:0]                MAX_STEPS   = 16'd255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [ACTION_W-1:0]        action,
  output logic [STATE_W-1:0]         current_state,
  output logic [STATE_W-1:0]         next_state,
  output logic signed [REWARD_W-1:0] next_reward,
  output logic                       valid,
  output logic                       episode_done,
  output logic [15:0]                episode_count,
  output logic [15:0]                step_count
);

`ifdef MAZE_ENV_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  fsm_state_t          state_q;
  fsm_state_t          state_d;
  logic [ACTION_W-1:0] action_q;
  logic [STATE_W-1:0]  position_q;
  logic [STATE_W-1:0]  target;
  logic                blocked;
  logic                goal;
  logic [15:0]         step_count_inc;
  logic                timeout_hit;
  logic                episode_end;
  logic                capture_action;
  logic                do_step;
  logic                do_restart;

  maze_move_calc #(
    .GOAL_STATE(GOAL_STATE)
  ) u_move_calc (
    .position(position_q),
    .action  (action_q),
    .wall_map(WALL_MAP),
    .target  (target),
    .blocked (blocked),
    .goal    (goal)
  );

  // Step counter value after this step (saturating), and whether this step
  // ends the episode. Timeout only counts when the feature is compiled in.
  always_comb begin
    step_count_inc = (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;
    timeout_hit    = TIMEOUT_EN && (step_count_inc == MAX_STEPS);
    episode_end    = goal || timeout_hit;
  end

  // FSM state register; reset pulls the FSM back to IDLE from any state,
  // which also abandons a step in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. en is only looked at in IDLE, so strobes during
  // STEP or RESTART are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = STEP;
      STEP:    state_d = episode_end ? RESTART : IDLE;
      RESTART: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode: which datapath action happens on the next edge.
  always_comb begin
    capture_action = (state_q == IDLE) && en;
    do_step        = (state_q == STEP);
    do_restart     = (state_q == RESTART);
  end

  // Datapath registers. The action is latched in IDLE so outputs never see
  // the live action input; STEP commits the move and result, RESTART puts
  // the agent back at the start and closes the episode.
  always_ff @(posedge clk) begin
    if (rst) begin
      action_q      <= '0;
      position_q    <= START_STATE;
      current_state <= START_STATE;
      next_state    <= START_STATE;
      next_reward   <= '0;
      valid         <= 1'b0;
      episode_done  <= 1'b0;
      episode_count <= 16'd0;
      step_count    <= 16'd0;
    end else begin
      valid        <= 1'b0;
      episode_done <= 1'b0;
      if (capture_action) action_q <= action;
      if (do_step) begin
        current_state <= position_q;
        next_state    <= target;
        position_q    <= target;
        next_reward   <= blocked ? REWARD_WALL : (goal ? REWARD_GOAL : REWARD_STEP);
        valid         <= 1'b1;
        episode_done  <= episode_end;
        step_count    <= step_count_inc;
      end
      if (do_restart) begin
        position_q    <= START_STATE;
        current_state <= START_STATE;
        next_state    <= START_STATE;
        step_count    <= 16'd0;
        episode_count <= episode_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/maze_environment.md
MAZE_ENVIRONMENT -- requirements
Module: maze_environment

Interface
REQ-001 Parameters SHALL be:
  START_STATE, 6'd0, episode start cell.
  GOAL_STATE, 6'd63, terminal cell.
  WALL_MAP, 64'h0, bit i = 1 marks cell i as a wall.
  REWARD_GOAL, 16'sd100, signed reward on reaching the goal.
  REWARD_STEP, -16'sd1, signed reward for a legal non-goal move.
  REWARD_WALL, -16'sd10, signed reward for a blocked or illegal move.
  MAX_STEPS, 16'd255, episode step limit.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  en  in  1  step strobe; action is sampled when en=1.
  action  in  4  one-hot move: bit0 up, bit1 down, bit2 left, bit3 right.
  current_state  out  6  agent position before the step.
  next_state  out  6  position after the step.
  next_reward  out  16  signed two's-complement reward for the step.
  valid  out  1  one-cycle pulse; step result present.
  episode_done  out  1  one-cycle pulse, coincident with valid, on goal or timeout.
  episode_count  out  16  completed episodes.
  step_count  out  16  steps taken in the current episode.

Function
REQ-003 State encoding SHALL be row = state[5:3], col = state[2:0]; up = row-1, down = row+1, left = col-1, right = col+1.
REQ-004 An FSM SHALL have states IDLE, STEP and RESTART.
REQ-005 IDLE → STEP when en=1; the action is registered in that cycle.
REQ-006 STEP SHALL last exactly one cycle. At its end, valid=1 with next_state, next_reward and current_state updated, giving a latency of 2 clk from the en edge to valid.
REQ-007 Move target: a target off-grid (row/col underflow or overflow) or a target with WALL_MAP bit = 1 SHALL leave position unchanged with reward REWARD_WALL.
REQ-008 An action that is not one-hot (zero or multiple bits) SHALL be treated as blocked: no move, REWARD_WALL.
REQ-009 A legal move to GOAL_STATE SHALL give reward REWARD_GOAL and episode_done=1; the FSM then goes STEP → RESTART.
REQ-010 Any other legal move SHALL give REWARD_STEP; the FSM then goes STEP → IDLE.
REQ-011 step_count SHALL increment on every valid step, blocked steps included, and saturate at 16'hFFFF.
REQ-012 RESTART SHALL last one cycle. It sets position, current_state and next_state to START_STATE, clears step_count, and increments episode_count with wrap at 16'hFFFF → 0. It then returns to IDLE.
REQ-013 en asserted during STEP or RESTART SHALL be ignored; no queuing.
REQ-014 Goal and timeout in the same step SHALL give REWARD_GOAL and a single episode_done pulse.
REQ-015 Position and rewards SHALL be registered; the outputs SHALL have no combinational path from action.

Reset
REQ-016 With rst=1 at a clk edge, all of the following SHALL hold: FSM → IDLE; current_state = next_state = START_STATE; next_reward = 0; valid = 0; episode_done = 0; episode_count = 0; step_count = 0.
REQ-017 rst SHALL override en and take effect in any FSM state, including mid-STEP. A step interrupted by reset produces no valid pulse.

Configuration
REQ-018 With macro MAZE_ENV_TIMEOUT_EN defined, a step that brings step_count to MAX_STEPS without reaching the goal SHALL assert episode_done with the step's normal reward, and the FSM SHALL then enter RESTART.
REQ-019 Without MAZE_ENV_TIMEOUT_EN, MAX_STEPS SHALL be ignored; episodes end only at the goal and step_count saturates per REQ-011.

Structure
REQ-020 Package maze_pkg SHALL hold STATE_W=6, ACTION_W=4, REWARD_W=16, the action one-hot constants (ACT_UP/DOWN/LEFT/RIGHT), the FSM state enum and the default reward constants.
REQ-021 Sub-module maze_move_calc SHALL hold the combinational logic: inputs position, action and WALL_MAP; outputs target position, blocked flag and goal flag. All registers stay in maze_environment.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset then en with action=4'b1000 at state 0: 2 cycles later valid=1, current_state=0, next_state=1, next_reward=-1, step_count=1.
- At state 0, action=4'b0001 (up, off-grid): next_state=0, next_reward=-10, valid=1.
- WALL_MAP bit 1 set, state 0, action right: next_state=0, next_reward=-10.
- Position 62, action right: next_state=63, next_reward=100, episode_done=1; the next cycle shows current_state=0, step_count=0, episode_count=1.
- MAZE_ENV_TIMEOUT_EN defined with MAX_STEPS=3: three steps without reaching the goal → episode_done on the 3rd valid, then restart to state 0. The same run without the macro gives no episode_done.
- action=4'b0011, then rst asserted in STEP: no valid pulse; all outputs at reset values; en held during STEP is ignored.
